// File: rtl/uart_pipe_phy.sv
// uart_pipe_phy
//   8N1 UART transceiver. It is the serial-line end of the valid/ready byte
//   pipes that usb_uart_core exposes, so a USB CDC link can drive a physical
//   UART at a fixed baud rate.
//   Transmit side: a byte is accepted with a valid/ready handshake and then
//   shifted out on uart_tx.
//   Receive side: uart_rx is synchronised and deserialised, and each byte is
//   presented through a one-byte holding register.
//
// Parameters
//   CLK_HZ   clock frequency in Hz
//   BAUD     line rate; CPB = CLK_HZ/BAUD clock cycles per bit (must be >= 4)
//
// Ports
//   clk_48mhz     system clock
//   reset         synchronous, active-high reset
//   tx_data       byte to transmit (from core uart_out_data)
//   tx_valid      tx_data is valid
//   tx_ready      transmitter accepts a byte this cycle (high only when idle)
//   rx_data       received byte (to core uart_in_data)
//   rx_valid      rx_data holds an unconsumed byte
//   rx_ready      downstream consumes rx_data this cycle
//   uart_tx       serial output, idle high
//   uart_rx       serial input, asynchronous to clk_48mhz
//   rx_overrun    sticky: a received byte was dropped; cleared only by reset
//   rx_frame_err  one-cycle pulse: the stop bit was sampled low
//
// All outputs are registered.
module uart_pipe_phy #(
  parameter int unsigned CLK_HZ = 48000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       uart_tx,
  input  logic       uart_rx,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam int unsigned CPB   = CLK_HZ / BAUD;
  localparam int unsigned HALF  = CPB / 2;
  localparam int unsigned CNT_W = $clog2(CPB + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

  // --------------------------------------------------------------------------
  // Transmitter
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  tx_state_t        tx_state, tx_state_n;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]       tx_bit, tx_bit_n;
  logic [7:0]       tx_shift, tx_shift_n;
  logic             uart_tx_n;
  logic             tx_ready_n;

  // State register; the line and ready outputs are registered from the
  // next-state view so they change on the same edge as the FSM.
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
      tx_ready <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      uart_tx  <= uart_tx_n;
      tx_ready <= tx_ready_n;
    end
  end

  // Next-state logic. Every bit, including start and stop, lasts CPB cycles.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    unique case (tx_state)
      TX_IDLE: begin
        if (tx_valid) begin
          tx_state_n = TX_START;
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_shift_n = tx_data;
        end
      end
      TX_START: begin
        if (tx_cnt == CNT_LAST) begin
          tx_state_n = TX_DATA;
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) begin
            tx_state_n = TX_STOP;
          end else begin
            tx_bit_n = tx_bit + 1'b1;
          end
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt == CNT_LAST) begin
          tx_state_n = TX_IDLE;
          tx_cnt_n   = '0;
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      default: begin
        tx_state_n = TX_IDLE;
        tx_cnt_n   = '0;
      end
    endcase
  end

  // Output logic: next value of the serial line and of tx_ready.
  always_comb begin
    uart_tx_n  = 1'b1;
    tx_ready_n = 1'b0;
    unique case (tx_state_n)
      TX_IDLE:  tx_ready_n = 1'b1;
      TX_START: uart_tx_n  = 1'b0;
      TX_DATA:  uart_tx_n  = tx_shift_n[tx_bit_n];
      TX_STOP:  uart_tx_n  = 1'b1;
      default:  uart_tx_n  = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Receiver
  // --------------------------------------------------------------------------
  logic rx_meta;
  logic rx_sync;

  // Two-flop synchroniser, reset to the idle (mark) level.
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  rx_state_t        rx_state, rx_state_n;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]       rx_bit, rx_bit_n;
  logic [7:0]       rx_shift, rx_shift_n;
  logic             rx_deliver;
  logic             rx_stop_bad;
  logic [7:0]       rx_data_n;
  logic             rx_valid_n;
  logic             rx_overrun_n;
  logic             rx_frame_err_n;

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_state     <= rx_state_n;
      rx_cnt       <= rx_cnt_n;
      rx_bit       <= rx_bit_n;
      rx_shift     <= rx_shift_n;
      rx_data      <= rx_data_n;
      rx_valid     <= rx_valid_n;
      rx_overrun   <= rx_overrun_n;
      rx_frame_err <= rx_frame_err_n;
    end
  end

  // Next-state logic. The start bit is re-checked half a bit after the
  // falling edge; every later sample is a full bit period on, which lands
  // near the middle of each bit.
  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt;
    rx_bit_n    = rx_bit;
    rx_shift_n  = rx_shift;
    rx_deliver  = 1'b0;
    rx_stop_bad = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (!rx_sync) begin
          rx_state_n = RX_START;
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt == CNT_MID) begin
          rx_cnt_n   = '0;
          rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_sync, rx_shift[7:1]};
          if (rx_bit == 3'd7) begin
            rx_state_n = RX_STOP;
          end else begin
            rx_bit_n = rx_bit + 1'b1;
          end
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_n = '0;
          if (rx_sync) begin
            rx_deliver = 1'b1;
            rx_state_n = RX_IDLE;
          end else begin
            rx_stop_bad = 1'b1;
            rx_state_n  = RX_WAIT_HIGH;
          end
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        // A held-low line (break) reports one framing error, not one per frame.
        if (rx_sync) begin
          rx_state_n = RX_IDLE;
        end
      end
      default: begin
        rx_state_n = RX_IDLE;
        rx_cnt_n   = '0;
      end
    endcase
  end

  // Output logic: holding register, overrun and framing flags.
  // A delivery coinciding with a consume replaces the byte and keeps
  // rx_valid high; a delivery into an unconsumed register is dropped.
  always_comb begin
    rx_data_n      = rx_data;
    rx_valid_n     = rx_valid;
    rx_overrun_n   = rx_overrun;
    rx_frame_err_n = rx_stop_bad;
    if (rx_deliver) begin
      if (!rx_valid || rx_ready) begin
        rx_data_n  = rx_shift;
        rx_valid_n = 1'b1;
      end else begin
        rx_overrun_n = 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      rx_valid_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_pipe_phy.sv
module tb_uart_pipe_phy;

  localparam int unsigned CLK_HZ = 48000000;
  localparam int unsigned BAUD   = 12000000;
  localparam int unsigned CPB    = CLK_HZ / BAUD;
  // Line-to-delivery latency: falling edge first sampled at P0, delivery edge.
  localparam int unsigned RX_LAT = 2 + CPB / 2 + 9 * CPB;

  logic       clk_48mhz = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       uart_tx;
  logic       uart_rx;
  logic       rx_overrun;
  logic       rx_frame_err;

  logic loop;
  logic rx_line;
  assign uart_rx = loop ? uart_tx : rx_line;

  always #5 clk_48mhz = ~clk_48mhz;

  uart_pipe_phy #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .clk_48mhz   (clk_48mhz),
    .reset       (reset),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .uart_tx     (uart_tx),
    .uart_rx     (uart_rx),
    .rx_overrun  (rx_overrun),
    .rx_frame_err(rx_frame_err)
  );

  int checks   = 0;
  int failures = 0;
  int fe_cnt   = 0;
  bit armed    = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Behavioural model: TX as a queue of per-cycle line levels, RX as a
  // list of scheduled frame-completion events applied to a holding register.
  // ------------------------------------------------------------------
  typedef struct {
    int unsigned at;
    logic [7:0]  b;
    logic        ok;
  } ev_t;

  int unsigned cyc = 0;
  logic        tq[$];
  ev_t         evq[$];
  ev_t         e;
  bit          m_ready = 1'b1;
  logic        m_tx    = 1'b1;
  logic        m_rv    = 1'b0;
  logic [7:0]  m_rd    = 8'h00;
  logic        m_ovr   = 1'b0;
  logic        m_fe    = 1'b0;
  logic [9:0]  fr;

  always @(posedge clk_48mhz) begin
    cyc = cyc + 1;
    if (reset) begin
      tq.delete();
      evq.delete();
      m_ready = 1'b1;
      m_tx    = 1'b1;
      m_rv    = 1'b0;
      m_rd    = 8'h00;
      m_ovr   = 1'b0;
      m_fe    = 1'b0;
    end else begin
      if (m_ready && tx_valid) begin
        fr = {1'b1, tx_data, 1'b0};
        for (int k = 0; k < 10; k++)
          for (int j = 0; j < int'(CPB); j++) tq.push_back(fr[k]);
        if (loop) evq.push_back(ev_t'{cyc + 1 + RX_LAT, tx_data, 1'b1});
      end
      if (tq.size() > 0) begin
        m_tx    = tq.pop_front();
        m_ready = 1'b0;
      end else begin
        m_tx    = 1'b1;
        m_ready = 1'b1;
      end
      m_fe = 1'b0;
      if (evq.size() > 0 && evq[0].at == cyc) begin
        e = evq.pop_front();
        if (e.ok) begin
          if (!m_rv || rx_ready) begin
            m_rd = e.b;
            m_rv = 1'b1;
          end else begin
            m_ovr = 1'b1;
          end
        end else begin
          m_fe = 1'b1;
          if (m_rv && rx_ready) m_rv = 1'b0;
        end
      end else if (m_rv && rx_ready) begin
        m_rv = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk_48mhz) begin
    if (armed) begin
      chk("uart_tx", uart_tx, m_tx);
      chk("tx_ready", tx_ready, m_ready);
      chk("rx_valid", rx_valid, m_rv);
      chk("rx_data", rx_data, m_rd);
      chk("rx_overrun", rx_overrun, m_ovr);
      chk("rx_frame_err", rx_frame_err, m_fe);
      if (rx_frame_err === 1'b1) fe_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_48mhz);
  endtask

  // Drive one 8N1 frame on rx_line and schedule its expected completion.
  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    evq.push_back(ev_t'{cyc + 1 + RX_LAT, b, stop});
    for (int k = 0; k < 10; k++) begin
      rx_line = f[k];
      tick(int'(CPB));
    end
  endtask

  logic [9:0] pat;
  logic       s[50];
  int         lowrun;
  int         rdy_low;
  int         bit_err;
  int         fe_base;

  initial begin
    reset    = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    rx_line  = 1'b1;
    loop     = 1'b0;
    tick(1);
    armed = 1'b1;
    chk("reset_uart_tx", uart_tx, 8'h01);
    chk("reset_tx_ready", tx_ready, 8'h01);
    chk("reset_rx_valid", rx_valid, 8'h00);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_rx_overrun", rx_overrun, 8'h00);
    chk("reset_rx_frame_err", rx_frame_err, 8'h00);
    tick(2);
    reset = 1'b0;
    tick(2);

    // Single byte 0xA5; a second request during the frame must be ignored.
    pat      = 10'b1101001010;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    bit_err  = 0;
    rdy_low  = 0;
    for (int i = 0; i < 41; i++) begin
      if (i < 40) begin
        if (uart_tx !== pat[i / 4]) bit_err++;
        if (tx_ready === 1'b0) rdy_low++;
      end
      if (i == 5) begin
        tx_data  = 8'h00;
        tx_valid = 1'b1;
      end
      if (i == 20) tx_valid = 1'b0;
      if (i == 40) chk("a5_ready_after", tx_ready, 8'h01);
      tick(1);
    end
    chk("a5_bit_errors", 8'(bit_err), 8'h00);
    chk("a5_ready_low_cycles", 8'(rdy_low), 8'd40);
    tick(3);

    // Back-to-back 0x00 then 0xFF with tx_valid held.
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    tick(1);
    tx_data = 8'hFF;
    for (int i = 0; i < 50; i++) begin
      s[i] = uart_tx;
      if (i == 41) tx_valid = 1'b0;
      tick(1);
    end
    lowrun = 0;
    while (lowrun < 50 && s[lowrun] == 1'b0) lowrun++;
    chk("b2b_low_run", 8'(lowrun), 8'd36);
    chk("b2b_stop_bit", {7'b0, s[36] & s[37] & s[38] & s[39]}, 8'h01);
    chk("b2b_second_start", {7'b0, s[41]}, 8'h00);
    tick(40);

    // RX 0x3C with rx_ready low, then 0x81 overruns.
    send_rx(8'h3C, 1'b1);
    tick(3);
    chk("rx3c_valid", rx_valid, 8'h01);
    chk("rx3c_data", rx_data, 8'h3C);
    chk("rx3c_overrun", rx_overrun, 8'h00);
    send_rx(8'h81, 1'b1);
    tick(3);
    chk("rx81_data_held", rx_data, 8'h3C);
    chk("rx81_overrun", rx_overrun, 8'h01);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    chk("consume_valid", rx_valid, 8'h00);
    chk("consume_overrun_sticky", rx_overrun, 8'h01);
    tick(5);

    // One-cycle glitch, then a framing error with the line held low.
    fe_base = fe_cnt;
    rx_line = 1'b0;
    tick(1);
    rx_line = 1'b1;
    tick(20);
    chk("glitch_valid", rx_valid, 8'h00);
    chk("glitch_frame_err_count", 8'(fe_cnt - fe_base), 8'h00);
    send_rx(8'h55, 1'b0);
    tick(16);
    rx_line = 1'b1;
    tick(10);
    chk("ferr_pulse_count", 8'(fe_cnt - fe_base), 8'h01);
    chk("ferr_valid", rx_valid, 8'h00);
    send_rx(8'h12, 1'b1);
    tick(3);
    chk("rx12_valid", rx_valid, 8'h01);
    chk("rx12_data", rx_data, 8'h12);
    tick(5);

    // Reset in the middle of a TX frame and an RX frame.
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    rx_line  = 1'b0;
    tick(1);
    tx_valid = 1'b0;
    tick(14);
    reset   = 1'b1;
    rx_line = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("midreset_uart_tx", uart_tx, 8'h01);
    chk("midreset_tx_ready", tx_ready, 8'h01);
    chk("midreset_rx_valid", rx_valid, 8'h00);
    chk("midreset_overrun", rx_overrun, 8'h00);
    tick(60);

    // Loopback 0x7E.
    fe_base = fe_cnt;
    loop    = 1'b1;
    tick(2);
    tx_data  = 8'h7E;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tick(50);
    chk("loop_valid", rx_valid, 8'h01);
    chk("loop_data", rx_data, 8'h7E);
    chk("loop_overrun", rx_overrun, 8'h00);
    chk("loop_frame_err_count", 8'(fe_cnt - fe_base), 8'h00);
    tick(5);

    armed = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
